// File: rtl/mem_responder.sv
`default_nettype none
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 16
`endif
`ifndef MEM_BANDWIDTH
`define MEM_BANDWIDTH 4
`endif
// +--------------------------------------------------------------------------+
// | mem_responder                                                            |
// | Memory-side model: in-order read responses with latency, gap and credit. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_responder #(
  parameter int ADDR_W          = `MEM_ADDR_SIZE,
  parameter int DATA_W          = `MEM_BANDWIDTH*8,
  parameter int DEPTH           = 4096,
  parameter int LATENCY         = 4,
  parameter int RESP_GAP        = 0,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   mem_req_valid,
  input  logic                                   mem_req_write,
  input  logic [ADDR_W-1:0]                      mem_addr,
  input  logic [DATA_W-1:0]                      mem_write_data,
  output logic                                   mem_ready,
  output logic [DATA_W-1:0]                      mem_data,
  output logic                                   mem_valid,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);
  localparam int GAP_W = (RESP_GAP > 0) ? $clog2(RESP_GAP+1) : 1;
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_X    = CNT_W'(MAX_OUTSTANDING);
  localparam logic [GAP_W-1:0] GAP_X    = GAP_W'(RESP_GAP);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING-1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  out_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              accept, rd_accept, wr_accept, in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_snap;

  assign mem_ready   = out_cnt < MAX_X;
  assign outstanding = out_cnt;
  assign accept      = mem_req_valid & mem_ready;
  assign rd_accept   = accept & ~mem_req_write;
  assign wr_accept   = accept & mem_req_write;
  assign in_range    = {1'b0, mem_addr} < DEPTH_X;
  assign idx         = mem_addr[IDX_W-1:0];
  assign rd_snap     = in_range ? mem[idx] : '0;

  // Storage is deliberately not reset; writes are ignored while in reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_accept && in_range) mem[idx] <= mem_write_data;
  end

  logic              in_valid;
  logic [DATA_W-1:0] in_data;

  generate
    if (LATENCY > 1) begin : g_pipe
      logic [LATENCY-2:0] v;
      logic [DATA_W-1:0]  d [LATENCY-1];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v <= '0;
        end else begin
          v[0] <= rd_accept;
          for (int i = 1; i < LATENCY-1; i++) v[i] <= v[i-1];
        end
      end

      always_ff @(posedge clk) begin
        d[0] <= rd_snap;
        for (int i = 1; i < LATENCY-1; i++) d[i] <= d[i-1];
      end

      assign in_valid = v[LATENCY-2];
      assign in_data  = d[LATENCY-2];
    end else begin : g_nopipe
      assign in_valid = rd_accept;
      assign in_data  = rd_snap;
    end
  endgenerate

  // The pipe's last stage counts as the LATENCY-th cycle: when the FIFO is
  // empty the arriving word bypasses it straight into the output register.
  logic [DATA_W-1:0] fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_ne, emit, push, pop;
  logic [DATA_W-1:0] emit_data;

  assign fifo_ne   = fifo_cnt != '0;
  assign emit      = (gap_cnt == '0) & (fifo_ne | in_valid);
  assign pop       = emit & fifo_ne;
  assign push      = in_valid & (fifo_ne | ~emit);
  assign emit_data = fifo_ne ? fifo[rd_ptr] : in_data;

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      gap_cnt   <= '0;
      out_cnt   <= '0;
      mem_valid <= 1'b0;
      mem_data  <= '0;
      addr_err  <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      fifo_cnt  <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      out_cnt   <= out_cnt + CNT_W'(rd_accept) - CNT_W'(mem_valid);
      mem_valid <= emit;
      if (emit) mem_data <= emit_data;
      // Loading on the emitting edge spaces pulses exactly RESP_GAP+1 apart.
      if (emit)                gap_cnt <= GAP_X;
      else if (gap_cnt != '0)  gap_cnt <= gap_cnt - GAP_W'(1);
      if (accept && !in_range) addr_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire
